// File: rtl/seed_ram_fill_engine_if.sv
// Wishbone write-master bus bundle between the seed-RAM fill engine and the seed-RAM port.
// The engine uses the master modport and the RAM side uses the slave modport.
interface seed_ram_fill_engine_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [DW-1:0]   wb_dat_o;
    logic [AW-1:0]   wb_adr_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_cab_o;
    logic            wb_ack_i;
    logic            wb_err_i;

    // Classic single-beat Wishbone: a transfer is offered while cyc/stb are high and
    // completes in the cycle the slave raises ack (success) or err (failure).
    modport master (
        output wb_dat_o, wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cab_o,
        input  wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_dat_o, wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cab_o,
        output wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/seed_ram_fill_engine.sv
// Wishbone master that fills a word-aligned seed-RAM region with a pattern, one write per word.
// Optional macro SEED_INIT_INCR_PATTERN_EN: word k carries pattern + k instead of the constant pattern.
module seed_ram_fill_engine #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MAX_RETRY = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [AW-1:0]           base_i,
    input  logic [AW-1:0]           len_i,
    input  logic [DW-1:0]           pattern_i,
    seed_ram_fill_engine_if.master  wb,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [AW-3:0]           remaining_o,
    output logic [1:0]              dbg_state_o,
    output logic [AW-3:0]           dbg_index_o
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_adr;
    logic [AW-3:0] r_remaining;
    logic [DW-1:0] r_pattern;
    logic [AW-3:0] r_index;
    logic [RW-1:0] r_retry;
    logic          r_err;
    logic          r_done;

    logic [AW-3:0] w_len_words;
    logic          w_start_ok;
    logic          w_acked;
    logic          w_erred;
    logic          w_retry_ok;
    logic          w_last_word;
    logic          w_done_next;
    logic          w_unused;

    assign w_len_words = len_i[AW-1:2];
    assign w_start_ok  = (r_state == S_IDLE) && start_i;
    // err wins over a simultaneous ack, so only a clean ack advances the fill
    assign w_acked     = (r_state == S_WRITE) && wb.wb_ack_i && !wb.wb_err_i;
    assign w_erred     = (r_state == S_WRITE) && wb.wb_err_i;
    assign w_retry_ok  = (r_retry < RETRY_LIMIT);
    assign w_last_word = (r_remaining == (AW-2)'(1));
    assign w_unused    = ^{base_i[1:0], len_i[1:0]};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i && (w_len_words != '0)) w_next_state = S_WRITE;
            end
            S_WRITE: begin
                if (abort_i)                   w_next_state = S_IDLE;
                else if (wb.wb_err_i)          w_next_state = w_retry_ok ? S_GAP : S_IDLE;
                else if (wb.wb_ack_i)          w_next_state = w_last_word ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                w_next_state = abort_i ? S_IDLE : S_WRITE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Every fill ends with exactly one done pulse: a busy->idle transition or an empty start.
    assign w_done_next = ((r_state != S_IDLE) && (w_next_state == S_IDLE)) ||
                         (w_start_ok && (w_len_words == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_adr       <= '0;
            r_remaining <= '0;
            r_pattern   <= '0;
            r_index     <= '0;
            r_retry     <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_done_next;
            if (w_start_ok) begin
                r_adr       <= {base_i[AW-1:2], 2'b00};
                r_remaining <= w_len_words;
                r_pattern   <= pattern_i;
                r_index     <= '0;
                r_retry     <= '0;
                r_err       <= 1'b0;
            end
            // An ack that coincides with abort still counts as a written word.
            if (w_acked) begin
                r_adr       <= r_adr + AW'(4);
                r_remaining <= r_remaining - (AW-2)'(1);
                r_index     <= r_index + (AW-2)'(1);
                r_retry     <= '0;
            end
            if (w_erred && !abort_i) begin
                if (w_retry_ok) r_retry <= r_retry + RW'(1);
                else            r_err   <= 1'b1;
            end
        end
    end

    assign wb.wb_cyc_o = (r_state == S_WRITE);
    assign wb.wb_stb_o = (r_state == S_WRITE);
    assign wb.wb_we_o  = (r_state == S_WRITE);
    assign wb.wb_adr_o = r_adr;
    assign wb.wb_sel_o = '1;
    assign wb.wb_cab_o = 1'b0;
`ifdef SEED_INIT_INCR_PATTERN_EN
    assign wb.wb_dat_o = r_pattern + DW'(r_index);
`else
    assign wb.wb_dat_o = r_pattern;
`endif

    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign remaining_o = r_remaining;
    assign dbg_state_o = r_state;
    assign dbg_index_o = r_index;

endmodule

// File: tb/tb_seed_ram_fill_engine.sv
// Directed bench for seed_ram_fill_engine: a zero-wait Wishbone responder checks each write
// against a queue of expected (address, data) pairs; the main sequence checks status and timing.
module tb_seed_ram_fill_engine;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          abort_i;
  logic [AW-1:0] base_i;
  logic [AW-1:0] len_i;
  logic [DW-1:0] pattern_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [AW-3:0] remaining_o;
  logic [1:0]    dbg_state_o;
  logic [AW-3:0] dbg_index_o;

  seed_ram_fill_engine_if #(.DW(DW), .AW(AW)) bus ();

  seed_ram_fill_engine #(.DW(DW), .AW(AW), .MAX_RETRY(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .base_i      (base_i),
    .len_i       (len_i),
    .pattern_i   (pattern_i),
    .wb          (bus.master),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .remaining_o (remaining_o),
    .dbg_state_o (dbg_state_o),
    .dbg_index_o (dbg_index_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_strobes = 0;
  int err_budget = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_dat(input logic [DW-1:0] p, input int k);
`ifdef SEED_INIT_INCR_PATTERN_EN
    return p + DW'(k);
`else
    return p;
`endif
  endfunction

  // Zero-wait slave: answers every strobe in the same cycle, with err while err_budget lasts.
  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      if (bus.wb_cyc_o === 1'b1) begin
        n_strobes++;
        check("wb_stb_we_sel_cab", {bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_cab_o}, 64'b1111110);
        check("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          check("wb_adr", bus.wb_adr_o, exp_q[0][AW+DW-1:DW]);
          check("wb_dat", bus.wb_dat_o, exp_q[0][DW-1:0]);
        end
        if (err_budget > 0) begin
          bus.wb_err_i = 1'b1;
          err_budget--;
        end else begin
          bus.wb_ack_i = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Pushes the first n_push expected writes, then pulses start; returns #1 into cycle 1.
  task automatic fire(input logic [AW-1:0] b, input logic [AW-1:0] l,
                      input logic [DW-1:0] p, input int n_push);
    logic [AW-1:0] a0;
    a0 = {b[AW-1:2], 2'b00};
    for (int k = 0; k < n_push; k++) exp_q.push_back({a0 + AW'(4 * k), exp_dat(p, k)});
    @(posedge clk); #1;
    start_i = 1'b1; base_i = b; len_i = l; pattern_i = p;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done_o !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", done_o, 1);
  endtask

  int lat;
  int s0;
  int words;
  logic [DW-1:0] rpat;
  logic [AW-1:0] rbase;
  logic seen_done;

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    base_i = '0; len_i = '0; pattern_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_err", err_o, 0);
    check("reset_remaining", remaining_o, 0);
    check("reset_strobes", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 0);
    check("reset_adr", bus.wb_adr_o, 0);
    check("reset_dat", bus.wb_dat_o, 0);
    check("reset_state", dbg_state_o, 0);
    rst = 1'b0;

    // Basic fill: 4 words of zero starting at 0x1000, done 8 cycles after start.
    s0 = n_strobes;
    fire(32'h1000, 32'd16, 32'h0, 4);
    check("basic_busy_c1", busy_o, 1);
    check("basic_cyc_c1", bus.wb_cyc_o, 1);
    check("basic_remaining_c1", remaining_o, 4);
    wait_done(lat);
    check("basic_latency", lat, 8);
    check("basic_busy_at_done", busy_o, 0);
    check("basic_err", err_o, 0);
    check("basic_remaining_end", remaining_o, 0);
    check("basic_strobes", n_strobes - s0, 4);
    check("basic_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    check("basic_done_one_cycle", done_o, 0);

    // All-ones pattern over two words.
    fire(32'h2000, 32'd8, 32'hFFFF_FFFF, 2);
    wait_done(lat);
    check("ones_latency", lat, 4);
    check("ones_queue_empty", exp_q.size(), 0);

    // Random aligned base, random pattern, 1..6 words.
    rpat  = $urandom;
    rbase = {$urandom_range(16'h0100, 16'hF000), 16'h0000} | {22'd0, 10'($urandom_range(0, 255) * 4)};
    words = $urandom_range(1, 6);
    fire(rbase, AW'(words * 4), rpat, words);
    wait_done(lat);
    check("rand_latency", lat, 2 * words);
    check("rand_queue_empty", exp_q.size(), 0);

    // Two errors on word 0, then success: three strobes on the same address.
    s0 = n_strobes;
    err_budget = 2;
    fire(32'h3000, 32'd8, 32'h1234_5678, 2);
    wait_done(lat);
    check("retry_latency", lat, 8);
    check("retry_strobes", n_strobes - s0, 4);
    check("retry_err", err_o, 0);
    check("retry_queue_empty", exp_q.size(), 0);

    // Four errors on word 0: retries exhausted.
    s0 = n_strobes;
    err_budget = 4;
    fire(32'h4000, 32'd12, 32'hCAFE_F00D, 3);
    wait_done(lat);
    check("exhaust_latency", lat, 8);
    check("exhaust_strobes", n_strobes - s0, 4);
    check("exhaust_err", err_o, 1);
    check("exhaust_remaining", remaining_o, 3);
    check("exhaust_busy", busy_o, 0);
    check("exhaust_unwritten", exp_q.size(), 3);
    exp_q.delete();
    @(posedge clk); #1;
    check("exhaust_err_sticky", err_o, 1);

    // Abort in the gap after the first of 8 words; a start while busy is ignored.
    s0 = n_strobes;
    fire(32'h5000, 32'd32, 32'h0BAD_BEEF, 1);
    check("abort_err_cleared", err_o, 0);
    start_i = 1'b1; base_i = 32'h9000; len_i = 32'd4;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("abort_gap_cyc", bus.wb_cyc_o, 0);
    check("abort_gap_busy", busy_o, 1);
    check("abort_gap_remaining", remaining_o, 7);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 1);
    check("abort_remaining", remaining_o, 7);
    check("abort_err", err_o, 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_more_cyc", n_strobes - s0, 1);
    check("abort_idle_remaining", remaining_o, 7);

    // Length below one word: immediate done, no bus cycle.
    s0 = n_strobes;
    fire(32'h6000, 32'd3, 32'h5555_5555, 0);
    check("short_done", done_o, 1);
    check("short_busy", busy_o, 0);
    check("short_cyc", bus.wb_cyc_o, 0);
    check("short_remaining", remaining_o, 0);
    @(posedge clk); #1;
    check("short_done_one_cycle", done_o, 0);
    check("short_strobes", n_strobes - s0, 0);

    // Address wraps from the top of the space to zero.
    fire(32'hFFFF_FFFC, 32'd8, 32'h0F0F_0F0F, 2);
    wait_done(lat);
    check("wrap_latency", lat, 4);
    check("wrap_queue_empty", exp_q.size(), 0);

    // Unaligned base and length: low two bits dropped.
    fire(32'h6003, 32'h0000_000B, 32'h7777_0000, 2);
    wait_done(lat);
    check("unaligned_latency", lat, 4);
    check("unaligned_queue_empty", exp_q.size(), 0);

    // Reset during WRITE: outputs return to reset values and the fill is forgotten.
    s0 = n_strobes;
    fire(32'h7000, 32'd16, 32'hA5A5_A5A5, 4);
    check("rst_in_write", bus.wb_cyc_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_strobes", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_remaining", remaining_o, 0);
    check("rst_adr", bus.wb_adr_o, 0);
    check("rst_dat", bus.wb_dat_o, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen_done = seen_done | done_o;
    end
    check("rst_no_done", seen_done, 0);
    check("rst_no_more_cyc", n_strobes - s0, 1);
    exp_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
